// File: rtl/instr_encoder_pkg.sv
// -----------------------------------------------------------------------------
// instr_encoder_pkg
//   Shared definitions for the RV32I instruction encoder: instruction format
//   codes, rejection codes, common opcodes, the control FSM state type and a
//   small helper that checks whether a value fits a signed field.
// -----------------------------------------------------------------------------
package instr_encoder_pkg;

  // Instruction formats (3-bit code on the fmt input); 6 and 7 are illegal.
  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  // Rejection codes reported on err_code.
  localparam logic [1:0] ERR_RANGE    = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_ULOW     = 2'd2;
  localparam logic [1:0] ERR_FMT      = 2'd3;

  // Common RV32I opcodes.
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // True when v is representable as a signed number of 'bits' bits, i.e. all
  // bits from the field's sign bit upward are copies of that sign bit.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] s;
    s = $signed(v) >>> (bits - 1);
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// -----------------------------------------------------------------------------
// instr_pack
//   Combinational field packer and legality check for one request.
//   Ports:
//     fmt, opcode, rd, rs1, rs2, funct3, funct7, imm : request fields
//     word     : packed 32-bit instruction (meaningful only when ok)
//     ok       : request is legal and should be written
//     err_code : reason for rejection when !ok
//   Priority when several checks fail: bad fmt > range > misaligned > U low bits.
// -----------------------------------------------------------------------------
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        ok,
  output logic [1:0]  err_code
);

  // B and J ranges stop at the largest even value, so the odd top value of the
  // signed field counts as out of range (range outranks misalignment).
  logic b_in_range;
  logic j_in_range;

  assign b_in_range = fits_signed(imm, 13) && (imm != 32'h0000_0FFF);
  assign j_in_range = fits_signed(imm, 21) && (imm != 32'h000F_FFFF);

  always_comb begin
    word     = '0;
    ok       = 1'b1;
    err_code = ERR_RANGE;
    case (fmt)
      FMT_R: begin
        word = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      FMT_I: begin
        word = {imm[11:0], rs1, funct3, rd, opcode};
        if (!fits_signed(imm, 12)) begin
          ok       = 1'b0;
          err_code = ERR_RANGE;
        end
      end
      FMT_S: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        if (!fits_signed(imm, 12)) begin
          ok       = 1'b0;
          err_code = ERR_RANGE;
        end
      end
      FMT_B: begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        if (!b_in_range) begin
          ok       = 1'b0;
          err_code = ERR_RANGE;
        end else if (imm[0]) begin
          ok       = 1'b0;
          err_code = ERR_MISALIGN;
        end
      end
      FMT_U: begin
        word = {imm[31:12], rd, opcode};
        if (imm[11:0] != 12'd0) begin
          ok       = 1'b0;
          err_code = ERR_ULOW;
        end
      end
      FMT_J: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        if (!j_in_range) begin
          ok       = 1'b0;
          err_code = ERR_RANGE;
        end else if (imm[0]) begin
          ok       = 1'b0;
          err_code = ERR_MISALIGN;
        end
      end
      default: begin
        ok       = 1'b0;
        err_code = ERR_FMT;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Sequential RV32I instruction assembler. Each accepted request is packed
//   into a 32-bit word and written to instruction memory through a one-entry
//   output register; illegal requests are consumed, dropped and flagged.
//
//   Handshakes (both sides): a transfer happens on a rising clk edge where
//   valid && ready are both high. A producer holds valid and its payload stable
//   until that edge; valid never depends on ready. in_ready is combinational
//   on out_ready so a new word can load in the same cycle the old one drains.
//
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     start, finish       program begin / end pulses
//     in_valid, in_ready  request handshake
//     fmt..imm            request fields
//     out_valid, out_ready, out_addr, out_data   imem write port
//     err_valid, err_code, err_count             rejection reporting
//     done                program complete
//     dbg_state           current control state (state_t encoding)
// -----------------------------------------------------------------------------
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          DEPTH     = 256,
  parameter int          CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             finish,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       fmt,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_addr,
  output logic [31:0]      out_data,
  output logic             err_valid,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] err_count,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int          WC_W      = $clog2(DEPTH + 1);
  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (DEPTH - 1));

  state_t          state;
  state_t          state_nxt;
  logic [WC_W-1:0] word_cnt;
  logic            room;
  logic            accept;
  logic            drain;
  logic            start_ok;
  logic [31:0]     pk_word;
  logic            pk_ok;
  logic [1:0]      pk_err;

  instr_pack u_pack (
    .fmt      (fmt),
    .opcode   (opcode),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .funct3   (funct3),
    .funct7   (funct7),
    .imm      (imm),
    .word     (pk_word),
    .ok       (pk_ok),
    .err_code (pk_err)
  );

  assign room      = word_cnt < WC_W'(DEPTH);
  assign in_ready  = (state == ST_ACTIVE) && (!out_valid || out_ready) && room;
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;
  assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign done      = (state == ST_DONE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_ACTIVE;
      // A request accepted together with finish still lands; the drain state
      // then waits for it to leave the output register.
      ST_ACTIVE: if (finish || !room) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (!out_valid) state_nxt = ST_DONE;
      ST_DONE:   if (start) state_nxt = ST_ACTIVE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output register, address/word counter and error reporting. out_addr
  // always names the slot of the pending (or next) word; it advances when a
  // word drains, so a same-cycle load lands at the new address.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= BASE_ADDR;
      word_cnt  <= '0;
      err_valid <= 1'b0;
      err_code  <= '0;
      err_count <= '0;
    end else begin
      err_valid <= 1'b0;
      if (start_ok) begin
        out_valid <= 1'b0;
        out_addr  <= BASE_ADDR;
        word_cnt  <= '0;
        err_count <= '0;
      end else begin
        if (drain) begin
          out_valid <= 1'b0;
          out_addr  <= (out_addr == LAST_ADDR) ? BASE_ADDR : out_addr + 32'd4;
        end
        if (accept) begin
          if (pk_ok) begin
            out_valid <= 1'b1;
            out_data  <= pk_word;
            word_cnt  <= word_cnt + WC_W'(1);
          end else begin
            err_valid <= 1'b1;
            err_code  <= pk_err;
            if (err_count != '1) err_count <= err_count + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//   Directed bench for instr_encoder with a 4-word program depth. One task per
//   scenario; every expected value is a hand-computed constant or derived by
//   decoding the emitted word back into its fields.
// -----------------------------------------------------------------------------
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, start, finish, in_valid, in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid, out_ready;
  logic [31:0] out_addr, out_data;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [7:0]  err_count;
  logic        done;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  instr_encoder #(.BASE_ADDR(32'h0), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .err_valid(err_valid), .err_code(err_code), .err_count(err_count),
    .done(done), .dbg_state(dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
  endtask

  // Holds the current request until it is accepted (bounded); returns #1
  // after the accepting edge with in_valid dropped.
  task automatic send(output logic accepted);
    accepted = 1'b0;
    for (int i = 0; i < 20 && !accepted; i++) begin
      if (in_ready) accepted = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1; @(posedge clk); #1; finish = 1'b0;
  endtask

  task automatic wait_done(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (err_valid !== 1'b0) begin n_err++; $display("FAIL reset_err_valid: got %b want 0", err_valid); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (out_addr !== 32'h0) begin n_err++; $display("FAIL reset_out_addr: got %h want 0", out_addr); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_cmp++; if (err_code !== 2'd0) begin n_err++; $display("FAIL reset_err_code: got %0d want 0", err_code); end
    n_cmp++; if (err_count !== 8'd0) begin n_err++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state_idle: got %0d want 0", dbg_state); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL idle_in_ready: got %b want 0", in_ready); end
  endtask

  task automatic test_i_type();
    logic acc;
    pulse_start();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL start_in_ready: got %b want 1", in_ready); end
    set_req(FMT_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    send(acc);
    n_cmp++; if (acc !== 1'b1) begin n_err++; $display("FAIL addi_accept: got %b want 1", acc); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL addi_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 32'hFFF00093) begin n_err++; $display("FAIL addi_data: got %h want fff00093", out_data); end
    n_cmp++; if (out_addr !== 32'h0) begin n_err++; $display("FAIL addi_addr: got %h want 0", out_addr); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL addi_drained: got %b want 0", out_valid); end
    n_cmp++; if (out_addr !== 32'h4) begin n_err++; $display("FAIL addi_addr_next: got %h want 4", out_addr); end
  endtask

  task automatic test_b_type();
    logic acc;
    set_req(FMT_B, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
    send(acc);
    n_cmp++; if (out_data !== 32'hFE208EE3 || out_valid !== 1'b1) begin n_err++; $display("FAIL beq_data: got %h/%b want fe208ee3/1", out_data, out_valid); end
    n_cmp++; if (out_addr !== 32'h4) begin n_err++; $display("FAIL beq_addr: got %h want 4", out_addr); end
    set_req(FMT_B, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    send(acc);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b_odd_nowrite: got %b want 0", out_valid); end
    n_cmp++; if (err_valid !== 1'b1 || err_code !== ERR_MISALIGN) begin n_err++; $display("FAIL b_odd_err: got %b/%0d want 1/1", err_valid, err_code); end
    n_cmp++; if (err_count !== 8'd1) begin n_err++; $display("FAIL b_odd_count: got %0d want 1", err_count); end
    // out of range and odd: range wins
    set_req(FMT_B, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd5001);
    send(acc);
    n_cmp++; if (err_valid !== 1'b1 || err_code !== ERR_RANGE) begin n_err++; $display("FAIL b_prio_err: got %b/%0d want 1/0", err_valid, err_code); end
    @(posedge clk); #1;
    n_cmp++; if (err_valid !== 1'b0) begin n_err++; $display("FAIL err_pulse_width: got %b want 0", err_valid); end
    n_cmp++; if (out_addr !== 32'h8 || err_count !== 8'd2) begin n_err++; $display("FAIL b_after: got addr %h cnt %0d want 8/2", out_addr, err_count); end
  endtask

  task automatic test_j_type();
    logic acc;
    set_req(FMT_J, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    send(acc);
    n_cmp++; if (out_data !== 32'h001000EF || out_addr !== 32'h8) begin n_err++; $display("FAIL jal_data: got %h@%h want 001000ef@8", out_data, out_addr); end
    set_req(FMT_J, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL j_big_ready: got %b want 1", in_ready); end
    send(acc);
    n_cmp++; if (err_valid !== 1'b1 || err_code !== ERR_RANGE) begin n_err++; $display("FAIL j_big_err: got %b/%0d want 1/0", err_valid, err_code); end
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL j_big_after: got rdy %b ov %b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_u_fmt();
    logic acc, seen;
    set_req(3'd6, 7'b0110011, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'h7FFF_FFFF);
    send(acc);
    n_cmp++; if (err_valid !== 1'b1 || err_code !== ERR_FMT) begin n_err++; $display("FAIL bad_fmt_err: got %b/%0d want 1/3", err_valid, err_code); end
    set_req(FMT_U, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
    send(acc);
    n_cmp++; if (err_valid !== 1'b1 || err_code !== ERR_ULOW) begin n_err++; $display("FAIL u_low_err: got %b/%0d want 1/2", err_valid, err_code); end
    n_cmp++; if (err_count !== 8'd5) begin n_err++; $display("FAIL u_low_count: got %0d want 5", err_count); end
    set_req(FMT_U, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    send(acc);
    n_cmp++; if (out_data !== 32'h123452B7 || out_addr !== 32'hC) begin n_err++; $display("FAIL lui_data: got %h@%h want 123452b7@c", out_data, out_addr); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    wait_done(seen);
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL u_done: got %b want 1", seen); end
  endtask

  task automatic test_back_to_back();
    logic acc, seen;
    pulse_start();
    n_cmp++; if (out_addr !== 32'h0 || done !== 1'b0 || err_count !== 8'd0) begin n_err++; $display("FAIL restart: got addr %h done %b cnt %0d want 0/0/0", out_addr, done, err_count); end
    out_ready = 1'b0;
    set_req(FMT_I, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    send(acc);
    n_cmp++; if (out_data !== 32'h00500113 || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_first: got %h/%b want 00500113/1", out_data, out_valid); end
    set_req(FMT_I, 7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (in_ready !== 1'b0 || out_data !== 32'h00500113 || out_addr !== 32'h0 || out_valid !== 1'b1) begin
        n_err++; $display("FAIL bp_hold%0d: got rdy %b data %h addr %h want 0/00500113/0", i, in_ready, out_data, out_addr);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    send(acc);
    n_cmp++; if (out_data !== 32'h80000193 || out_addr !== 32'h4 || out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_1: got %h@%h want 80000193@4", out_data, out_addr); end
    set_req(FMT_S, 7'b0100011, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'hFFFF_FFFC);
    send(acc);
    n_cmp++; if (out_data !== 32'hFE512E23 || out_addr !== 32'h8 || out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_2: got %h@%h want fe512e23@8", out_data, out_addr); end
    set_req(FMT_R, 7'b0110011, 5'd6, 5'd7, 5'd8, 3'd0, 7'b0100000, 32'h0);
    send(acc);
    n_cmp++; if (out_data !== 32'h40838333 || out_addr !== 32'hC || out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_3: got %h@%h want 40838333@c", out_data, out_addr); end
    // fifth request must not be taken
    set_req(FMT_I, 7'b0010011, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL depth_ready%0d: got %b want 0", i, in_ready); end
      @(posedge clk); #1;
    end
    wait_done(seen);
    in_valid = 1'b0;
    n_cmp++; if (seen !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL depth_done: got %b/%b want 1/0", seen, out_valid); end
    pulse_start();
    n_cmp++; if (out_addr !== 32'h0 || dbg_state !== 2'd1) begin n_err++; $display("FAIL depth_restart: got %h st %0d want 0/1", out_addr, dbg_state); end
    pulse_finish();
    wait_done(seen);
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL empty_done: got %b want 1", seen); end
  endtask

  task automatic test_finish_accept();
    logic acc, seen;
    pulse_start();
    set_req(FMT_I, 7'b0010011, 5'd4, 5'd4, 5'd0, 3'd7, 7'd0, 32'd2047);
    finish = 1'b1;
    send(acc);
    finish = 1'b0;
    // ANDI x4,x4,2047 -> 7ff27213
    n_cmp++; if (acc !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'h7FF27213) begin n_err++; $display("FAIL fin_accept: got %b/%b/%h want 1/1/7ff27213", acc, out_valid, out_data); end
    wait_done(seen);
    n_cmp++; if (seen !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL fin_done: got %b/%b want 1/0", seen, out_valid); end
  endtask

  task automatic test_round_trip();
    logic acc, seen, fld_ok;
    logic [2:0] f; logic [6:0] op, f7; logic [4:0] d, s1, s2; logic [2:0] f3;
    logic [31:0] im, w, dimm;
    for (int p = 0; p < 3; p++) begin
      pulse_start();
      for (int k = 0; k < DEPTH; k++) begin
        f = 3'($urandom_range(0, 5));
        op = 7'($urandom_range(0, 127)); f7 = 7'($urandom_range(0, 127));
        d = 5'($urandom_range(0, 31)); s1 = 5'($urandom_range(0, 31)); s2 = 5'($urandom_range(0, 31));
        f3 = 3'($urandom_range(0, 7));
        case (f)
          FMT_I, FMT_S: im = $urandom_range(0, 4095) - 32'd2048;
          FMT_B:        im = ($urandom_range(0, 4095) - 32'd2048) * 2;
          FMT_J:        im = ($urandom_range(0, 1048575) - 32'd524288) * 2;
          FMT_U:        im = $urandom() & 32'hFFFF_F000;
          default:      im = $urandom();
        endcase
        set_req(f, op, d, s1, s2, f3, f7, im);
        send(acc);
        w = out_data;
        n_cmp++; if (acc !== 1'b1 || out_valid !== 1'b1 || out_addr !== 32'(4 * k)) begin n_err++; $display("FAIL rt_write p%0d k%0d: got %b/%b@%h want 1/1@%h", p, k, acc, out_valid, out_addr, 32'(4 * k)); end
        fld_ok = (w[6:0] == op);
        dimm = 32'h0;
        case (f)
          FMT_R: fld_ok = fld_ok && w[11:7] == d && w[14:12] == f3 && w[19:15] == s1 && w[24:20] == s2 && w[31:25] == f7;
          FMT_I: begin fld_ok = fld_ok && w[11:7] == d && w[14:12] == f3 && w[19:15] == s1; dimm = {{20{w[31]}}, w[31:20]}; end
          FMT_S: begin fld_ok = fld_ok && w[14:12] == f3 && w[19:15] == s1 && w[24:20] == s2; dimm = {{20{w[31]}}, w[31:25], w[11:7]}; end
          FMT_B: begin fld_ok = fld_ok && w[14:12] == f3 && w[19:15] == s1 && w[24:20] == s2; dimm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0}; end
          FMT_U: begin fld_ok = fld_ok && w[11:7] == d; dimm = {w[31:12], 12'h0}; end
          default: begin fld_ok = fld_ok && w[11:7] == d; dimm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0}; end
        endcase
        n_cmp++; if (fld_ok !== 1'b1) begin n_err++; $display("FAIL rt_fields fmt%0d: got word %h for op %h rd %0d rs1 %0d rs2 %0d f3 %0d f7 %h", f, w, op, d, s1, s2, f3, f7); end
        if (f != FMT_R) begin
          n_cmp++; if (dimm !== im) begin n_err++; $display("FAIL rt_imm fmt%0d: got %h want %h (word %h)", f, dimm, im, w); end
        end
      end
      wait_done(seen);
      n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL rt_done p%0d: got %b want 1", p, seen); end
    end
  endtask

  task automatic test_reset_mid();
    logic acc;
    pulse_start();
    out_ready = 1'b0;
    set_req(FMT_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    send(acc);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_pending: got %b want 1", out_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 32'h0 || out_addr !== 32'h0 || dbg_state !== 2'd0) begin
      n_err++; $display("FAIL mid_reset: got ov %b rdy %b data %h addr %h st %0d want 0/0/0/0/0", out_valid, in_ready, out_data, out_addr, dbg_state);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_i_type();
    test_b_type();
    test_j_type();
    test_u_fmt();
    test_back_to_back();
    test_finish_accept();
    test_round_trip();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
